controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
- Multicycle control FSM for the 3-bit-opcode processor: ADD, COPY, READ, WRITE, IFZERO, JUMP, SET, STOP.
- Sequences each instruction through fetch, decode, execute, memory and writeback over several cycles.
- Waits on a memory-ready handshake for every memory access; halts on STOP or on a memory timeout.
- Drives the same datapath strobes as the single-cycle control unit, plus an IR write enable and status outputs.

Parameters:
TIMEOUT_MEM, 15, max cycles spent waiting for mem_pronto in BUSCA or MEM before entering ERRO (range 1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  3  opcode field of the instruction register; valid from DECOD onward
Zero  in  1  register-under-test == 0 flag from register file (used by IFZERO)
mem_pronto  in  1  memory ready: read data valid / write accepted this cycle
EscPC  out  1  PC write enable
EscIR  out  1  instruction register write enable
EscReg  out  1  register file write enable
EscMEM  out  1  memory write strobe
LerMEM  out  1  memory read strobe
Ji  out  1  PC source = jump target
Beqz  out  1  PC source = branch target
ULAOp  out  2  00 add, 01 pass-B, 10 pass-immediate, 11 address add
ULAFonte  out  2  00 register, 01 immediate, 10 constant 1
EndFonte_MEM  out  1  memory address source: 0 = PC, 1 = ALU result
FonteEscReg  out  1  writeback source: 0 = ALU, 1 = memory
RegFonte  out  1  destination register field select
STOP  out  1  processor halted
erro  out  1  halted by memory timeout
estado  out  3  current FSM state code
instr_concluida  out  1  one-cycle pulse in the final cycle of each instruction

Behaviour:
- States and codes: BUSCA=0, DECOD=1, EXEC=2, MEM=3, ESCRITA=4, PARADO=5, ERRO=6, ESPERA=7.
- Reset:
  - On the clock edge with reset=1: estado<=BUSCA; timeout counter<=0.
  - While reset=1: all strobes, STOP, erro and instr_concluida are forced to 0.
  - Reset in any state, including PARADO and ERRO, returns to BUSCA.
- Outputs are combinational from estado, the latched opcode, Zero and mem_pronto. Every strobe not listed for a state is 0.
- BUSCA:
  - LerMEM=1, EndFonte_MEM=0.
  - When mem_pronto=1: EscIR=1 and EscPC=1 (PC+1: ULAFonte=10, ULAOp=00), then go to DECOD.
  - Otherwise stay in BUSCA.
- DECOD:
  - Latch opcode internally.
  - STOP opcode goes to PARADO; every other opcode goes to EXEC.
- EXEC, by opcode:
  - ADD: ULAOp=00, ULAFonte=00, go to ESCRITA.
  - COPY: ULAOp=01, ULAFonte=00, go to ESCRITA.
  - SET: ULAOp=10, ULAFonte=01, go to ESCRITA.
  - READ/WRITE: ULAOp=11, ULAFonte=01, go to MEM.
  - JUMP: Ji=1, EscPC=1, instr_concluida=1, go to BUSCA.
  - IFZERO: Beqz=1, EscPC=Zero, instr_concluida=1, go to BUSCA.
- MEM:
  - EndFonte_MEM=1. READ asserts LerMEM=1; WRITE asserts EscMEM=1.
  - Strobes are held until mem_pronto=1.
  - On that cycle: READ goes to ESCRITA; WRITE asserts instr_concluida=1 and goes to BUSCA.
- ESCRITA:
  - EscReg=1, RegFonte=1, instr_concluida=1, go to BUSCA.
  - FonteEscReg=1 for READ, 0 otherwise.
- Latency with mem_pronto already high:
  - ADD/COPY/SET: 4 cycles.
  - READ: 5 cycles.
  - WRITE: 4 cycles.
  - JUMP/IFZERO: 3 cycles.
  - STOP: 2 cycles to PARADO.
  - Each wait cycle on mem_pronto adds 1.
- Timeout:
  - The counter increments on each BUSCA or MEM cycle with mem_pronto=0, and clears on mem_pronto=1 or on leaving the state.
  - When the counter reaches TIMEOUT_MEM, go to ERRO on that edge; no strobe is issued in the transition cycle.
- PARADO: STOP=1, no strobes; held until reset.
- ERRO: STOP=1 and erro=1; held until reset.
- mem_pronto outside BUSCA/MEM is ignored.
- Zero is sampled only in EXEC for IFZERO.

Optional Feature:
SINGLE_STEP_EN:
- Defined:
  - Adds input port passo (1 bit).
  - Wherever instr_concluida=1, the next state is ESPERA instead of BUSCA.
  - ESPERA: no strobes; on passo=1, go to BUSCA on the next edge.
  - The STOP opcode still goes to PARADO.
- Undefined: no passo port; ESPERA is unreachable and decodes as BUSCA.

Test Plan:
- Reset, then ADD with mem_pronto=1 -> estado 0,1,2,4,0; EscIR=EscPC=1 in cycle 1; EscReg=1 with ULAOp=00 in cycle 4; one instr_concluida pulse.
- READ with mem_pronto low for 3 MEM cycles -> LerMEM and EndFonte_MEM=1 held 4 cycles; then ESCRITA with FonteEscReg=1, EscReg=1; 8 cycles total.
- IFZERO with Zero=0, then with Zero=1 -> 3 cycles each; Beqz=1 in EXEC; EscPC=0 and 1 respectively; JUMP gives Ji=1, EscPC=1.
- STOP opcode, then ADD opcode for 20 cycles -> PARADO after 2 cycles, STOP=1 constant, all strobes 0; reset -> BUSCA with STOP=0.
- mem_pronto=0 forever in BUSCA with TIMEOUT_MEM=15 -> estado=6, erro=1, STOP=1 at cycle 16; reset in ERRO clears it.
- SINGLE_STEP_EN defined, COPY -> estado=7 after ESCRITA and held until passo=1, then BUSCA on the next cycle.

Source files
------------

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control FSM for the 3-bit-opcode CPU.
// Opcodes: ADD=0 COPY=1 READ=2 WRITE=3 IFZERO=4 JUMP=5 SET=6 STOP=7.
// Inputs : clock, reset (sync, active-high), opcode, Zero, mem_pronto
//          (+ passo when SINGLE_STEP_EN is defined).
// Outputs: datapath strobes (EscPC EscIR EscReg EscMEM LerMEM Ji Beqz),
//          ULAOp, ULAFonte, EndFonte_MEM, FonteEscReg, RegFonte,
//          status (STOP erro estado instr_concluida).
// Option : `define SINGLE_STEP_EN parks the FSM in ESPERA after each
//          completed instruction until passo=1.
module controle_multiciclo #(
  parameter int unsigned TIMEOUT_MEM = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       Zero,
  input  logic       mem_pronto,
`ifdef SINGLE_STEP_EN
  input  logic       passo,
`endif
  output logic       EscPC,
  output logic       EscIR,
  output logic       EscReg,
  output logic       EscMEM,
  output logic       LerMEM,
  output logic       Ji,
  output logic       Beqz,
  output logic [1:0] ULAOp,
  output logic [1:0] ULAFonte,
  output logic       EndFonte_MEM,
  output logic       FonteEscReg,
  output logic       RegFonte,
  output logic       STOP,
  output logic       erro,
  output logic [2:0] estado,
  output logic       instr_concluida
);

  typedef enum logic [2:0] {
    BUSCA   = 3'd0,
    DECOD   = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    ESCRITA = 3'd4,
    PARADO  = 3'd5,
    ERRO    = 3'd6,
    ESPERA  = 3'd7
  } estado_t;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_COPY   = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd2;
  localparam logic [2:0] OP_WRITE  = 3'd3;
  localparam logic [2:0] OP_IFZERO = 3'd4;
  localparam logic [2:0] OP_JUMP   = 3'd5;
  localparam logic [2:0] OP_SET    = 3'd6;
  localparam logic [2:0] OP_STOP   = 3'd7;

  // Last wait cycle allowed before giving up on memory.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_MEM - 1);

`ifdef SINGLE_STEP_EN
  localparam estado_t POS_INSTR = ESPERA;
`else
  localparam estado_t POS_INSTR = BUSCA;
`endif

  estado_t    est;
  estado_t    nxt;
  logic [7:0] cnt;
  logic [7:0] cntNxt;
  logic [2:0] opLat;
  logic       expira;

  always_ff @(posedge clock) begin
    if (reset) begin
      est   <= BUSCA;
      cnt   <= '0;
      opLat <= '0;
    end else begin
      est <= nxt;
      cnt <= cntNxt;
      if (est == DECOD) opLat <= opcode;
    end
  end

  // Timeout fires on the final allowed wait cycle; that cycle is
  // spent silently so no access is left half-issued.
  assign expira = (cnt == CNT_LAST) && !mem_pronto;
  assign estado = est;

  always_comb begin
    nxt             = est;
    cntNxt          = '0;
    EscPC           = 1'b0;
    EscIR           = 1'b0;
    EscReg          = 1'b0;
    EscMEM          = 1'b0;
    LerMEM          = 1'b0;
    Ji              = 1'b0;
    Beqz            = 1'b0;
    ULAOp           = 2'b00;
    ULAFonte        = 2'b00;
    EndFonte_MEM    = 1'b0;
    FonteEscReg     = 1'b0;
    RegFonte        = 1'b0;
    STOP            = 1'b0;
    erro            = 1'b0;
    instr_concluida = 1'b0;

    unique case (est)
`ifdef SINGLE_STEP_EN
      BUSCA: begin
`else
      BUSCA, ESPERA: begin
`endif
        if (expira) begin
          nxt = ERRO;
        end else begin
          LerMEM = 1'b1;
          if (mem_pronto) begin
            EscIR    = 1'b1;
            EscPC    = 1'b1;
            ULAFonte = 2'b10;
            nxt      = DECOD;
          end else begin
            cntNxt = cnt + 8'd1;
          end
        end
      end

      DECOD: begin
        nxt = (opcode == OP_STOP) ? PARADO : EXEC;
      end

      EXEC: begin
        unique case (1'b1)
          opLat == OP_ADD: begin
            nxt = ESCRITA;
          end
          opLat == OP_COPY: begin
            ULAOp = 2'b01;
            nxt   = ESCRITA;
          end
          opLat == OP_SET: begin
            ULAOp    = 2'b10;
            ULAFonte = 2'b01;
            nxt      = ESCRITA;
          end
          opLat == OP_READ,
          opLat == OP_WRITE: begin
            ULAOp    = 2'b11;
            ULAFonte = 2'b01;
            nxt      = MEM;
          end
          opLat == OP_JUMP: begin
            Ji              = 1'b1;
            EscPC           = 1'b1;
            instr_concluida = 1'b1;
            nxt             = POS_INSTR;
          end
          opLat == OP_IFZERO: begin
            Beqz            = 1'b1;
            EscPC           = Zero;
            instr_concluida = 1'b1;
            nxt             = POS_INSTR;
          end
          default: begin
            nxt = PARADO;
          end
        endcase
      end

      MEM: begin
        if (expira) begin
          nxt = ERRO;
        end else begin
          EndFonte_MEM = 1'b1;
          if (opLat == OP_READ) LerMEM = 1'b1;
          else                  EscMEM = 1'b1;
          if (mem_pronto) begin
            if (opLat == OP_READ) begin
              nxt = ESCRITA;
            end else begin
              instr_concluida = 1'b1;
              nxt             = POS_INSTR;
            end
          end else begin
            cntNxt = cnt + 8'd1;
          end
        end
      end

      ESCRITA: begin
        EscReg          = 1'b1;
        RegFonte        = 1'b1;
        FonteEscReg     = (opLat == OP_READ);
        instr_concluida = 1'b1;
        nxt             = POS_INSTR;
      end

      PARADO: begin
        STOP = 1'b1;
      end

      ERRO: begin
        STOP = 1'b1;
        erro = 1'b1;
      end

`ifdef SINGLE_STEP_EN
      ESPERA: begin
        if (passo) nxt = BUSCA;
      end
`endif

      default: begin
        nxt = BUSCA;
      end
    endcase

    if (reset) begin
      EscPC           = 1'b0;
      EscIR           = 1'b0;
      EscReg          = 1'b0;
      EscMEM          = 1'b0;
      LerMEM          = 1'b0;
      Ji              = 1'b0;
      Beqz            = 1'b0;
      ULAOp           = 2'b00;
      ULAFonte        = 2'b00;
      EndFonte_MEM    = 1'b0;
      FonteEscReg     = 1'b0;
      RegFonte        = 1'b0;
      STOP            = 1'b0;
      erro            = 1'b0;
      instr_concluida = 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: randomized scoreboard bench for the
// multicycle control FSM; expected cycles come from an instruction model.
module tb_controle_multiciclo;

  localparam int TO = 15;

  localparam logic [2:0] ADD    = 3'd0;
  localparam logic [2:0] COPY   = 3'd1;
  localparam logic [2:0] READ   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] IFZERO = 3'd4;
  localparam logic [2:0] JUMP   = 3'd5;
  localparam logic [2:0] SET    = 3'd6;
  localparam logic [2:0] STOPOP = 3'd7;

  typedef struct packed {
    logic [2:0] estado;
    logic       EscPC;
    logic       EscIR;
    logic       EscReg;
    logic       EscMEM;
    logic       LerMEM;
    logic       Ji;
    logic       Beqz;
    logic [1:0] ULAOp;
    logic [1:0] ULAFonte;
    logic       EndFonte_MEM;
    logic       FonteEscReg;
    logic       RegFonte;
    logic       STOP;
    logic       erro;
    logic       instr_concluida;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = '0;
  logic       Zero = 1'b0;
  logic       mem_pronto = 1'b0;
`ifdef SINGLE_STEP_EN
  logic       passo = 1'b0;
`endif
  logic       EscPC, EscIR, EscReg, EscMEM, LerMEM, Ji, Beqz;
  logic [1:0] ULAOp, ULAFonte;
  logic       EndFonte_MEM, FonteEscReg, RegFonte;
  logic       STOP, erro, instr_concluida;
  logic [2:0] estado;

  obs_t  expQ[$];
  string tagQ[$];
  int    nChk  = 0;
  int    nFail = 0;

  always #5 clock = ~clock;

  controle_multiciclo #(.TIMEOUT_MEM(TO)) dut (
    .clock(clock),
    .reset(reset),
    .opcode(opcode),
    .Zero(Zero),
    .mem_pronto(mem_pronto),
`ifdef SINGLE_STEP_EN
    .passo(passo),
`endif
    .EscPC(EscPC),
    .EscIR(EscIR),
    .EscReg(EscReg),
    .EscMEM(EscMEM),
    .LerMEM(LerMEM),
    .Ji(Ji),
    .Beqz(Beqz),
    .ULAOp(ULAOp),
    .ULAFonte(ULAFonte),
    .EndFonte_MEM(EndFonte_MEM),
    .FonteEscReg(FonteEscReg),
    .RegFonte(RegFonte),
    .STOP(STOP),
    .erro(erro),
    .estado(estado),
    .instr_concluida(instr_concluida)
  );

  // Monitor: one observation per cycle, compared against the scoreboard.
  always @(negedge clock) begin
    obs_t  a;
    obs_t  e;
    string t;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      a = '{estado, EscPC, EscIR, EscReg, EscMEM, LerMEM, Ji, Beqz,
            ULAOp, ULAFonte, EndFonte_MEM, FonteEscReg, RegFonte,
            STOP, erro, instr_concluida};
      nChk++;
      if (a !== e) begin
        nFail++;
        $display("FAIL %s @%0t: got %b required %b", t, $time, a, e);
      end
    end
  end

  function automatic obs_t idle(input logic [2:0] s);
    obs_t o;
    o = '0;
    o.estado = s;
    return o;
  endfunction

  task automatic step(input logic mp, input logic z,
                      input obs_t e, input string tag);
    mem_pronto = mp;
    Zero       = z;
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset      = 1'b1;
    mem_pronto = 1'($urandom);
    @(posedge clock);
    #1;
    step(1'($urandom), 1'($urandom), idle(3'd0), "reset");
    reset = 1'b0;
  endtask

  task automatic holdErro();
    obs_t o;
    o = idle(3'd6);
    o.STOP = 1'b1;
    o.erro = 1'b1;
    repeat (4) begin
      opcode = 3'($urandom);
      step(1'($urandom), 1'($urandom), o, "erro");
    end
  endtask

  task automatic fim();
`ifdef SINGLE_STEP_EN
    bit p;
    do begin
      p     = ($urandom_range(0, 2) == 0);
      passo = p;
      step(1'($urandom), 1'($urandom), idle(3'd7), "espera");
    end while (!p);
    passo = 1'b0;
`endif
  endtask

  // Instruction model: bw/mw = memory wait cycles in fetch/access,
  // zf < 0 means random Zero in EXEC. halted=1 when FSM needs reset.
  task automatic runInstr(input logic [2:0] op, input int bw,
                          input int mw, input int zf,
                          output bit halted);
    obs_t o;
    logic z;
    bit   mem;
    halted = 1'b0;
    for (int k = 0; k < bw; k++) begin
      opcode = 3'($urandom);
      if (k == TO - 1) begin
        step(1'b0, 1'($urandom), idle(3'd0), "busca_timeout");
        holdErro();
        halted = 1'b1;
        return;
      end
      o = idle(3'd0);
      o.LerMEM = 1'b1;
      step(1'b0, 1'($urandom), o, "busca_wait");
    end
    o = idle(3'd0);
    o.LerMEM   = 1'b1;
    o.EscIR    = 1'b1;
    o.EscPC    = 1'b1;
    o.ULAFonte = 2'b10;
    step(1'b1, 1'($urandom), o, "busca");

    opcode = op;
    step(1'($urandom), 1'($urandom), idle(3'd1), "decod");

    if (op == STOPOP) begin
      o = idle(3'd5);
      o.STOP = 1'b1;
      repeat (6) begin
        opcode = ADD;
        step(1'($urandom), 1'($urandom), o, "parado");
      end
      halted = 1'b1;
      return;
    end

    z   = (zf < 0) ? 1'($urandom) : 1'(zf);
    mem = (op == READ) || (op == WRITE);
    o   = idle(3'd2);
    case (op)
      COPY:   o.ULAOp = 2'b01;
      SET:    begin o.ULAOp = 2'b10; o.ULAFonte = 2'b01; end
      READ,
      WRITE:  begin o.ULAOp = 2'b11; o.ULAFonte = 2'b01; end
      JUMP:   begin o.Ji = 1'b1; o.EscPC = 1'b1;
                    o.instr_concluida = 1'b1; end
      IFZERO: begin o.Beqz = 1'b1; o.EscPC = z;
                    o.instr_concluida = 1'b1; end
      default: ;
    endcase
    step(1'($urandom), z, o, "exec");
    if (op == JUMP || op == IFZERO) begin
      fim();
      return;
    end

    if (mem) begin
      for (int k = 0; k < mw; k++) begin
        if (k == TO - 1) begin
          step(1'b0, 1'($urandom), idle(3'd3), "mem_timeout");
          holdErro();
          halted = 1'b1;
          return;
        end
        o = idle(3'd3);
        o.EndFonte_MEM = 1'b1;
        o.LerMEM       = (op == READ);
        o.EscMEM       = (op == WRITE);
        step(1'b0, 1'($urandom), o, "mem_wait");
      end
      o = idle(3'd3);
      o.EndFonte_MEM    = 1'b1;
      o.LerMEM          = (op == READ);
      o.EscMEM          = (op == WRITE);
      o.instr_concluida = (op == WRITE);
      step(1'b1, 1'($urandom), o, "mem");
      if (op == WRITE) begin
        fim();
        return;
      end
    end

    o = idle(3'd4);
    o.EscReg          = 1'b1;
    o.RegFonte        = 1'b1;
    o.FonteEscReg     = (op == READ);
    o.instr_concluida = 1'b1;
    step(1'($urandom), 1'($urandom), o, "escrita");
    fim();
  endtask

  function automatic int pickWait();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return TO;
    if (r == 1) return TO - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    bit h;
    logic [2:0] op;
    doReset();
    runInstr(ADD, 0, 0, -1, h);
    runInstr(READ, 0, 3, -1, h);
    runInstr(IFZERO, 0, 0, 0, h);
    runInstr(IFZERO, 0, 0, 1, h);
    runInstr(JUMP, 1, 0, -1, h);
    runInstr(WRITE, 2, TO - 1, -1, h);
    runInstr(STOPOP, 0, 0, -1, h);
    doReset();
    runInstr(ADD, TO, 0, -1, h);
    doReset();
    runInstr(WRITE, 0, TO, -1, h);
    doReset();
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom);
      if (op == STOPOP && $urandom_range(0, 2) != 0) op = SET;
      runInstr(op, pickWait(), pickWait(), -1, h);
      if (h) doReset();
    end
    @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL drain: %0d left, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
